// File: rtl/mips_cpu_bus_master.sv
// Avalon-MM bus master for the MIPS core: arbitrates instruction fetches and
// data loads/stores (data first), runs one single-word transfer at a time,
// returns read data with a one-cycle valid pulse, and aborts stalled
// transfers through a waitrequest watchdog.
module mips_cpu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_wdata,
  output logic        data_ready,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  // Avalon-MM master
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        we_q, we_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_rdata_q, instr_rdata_d;
  logic        data_valid_q, data_valid_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        bus_error_q, bus_error_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_hit;

  // Byte-offset bits are dropped: the bus is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr[1:0], data_addr[1:0]};

  // The abort fires on the stalled edge that brings the count to TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == (TIMEOUT_CYCLES - 1));

  // Next-state, captured request and registered bus/response values.
  always_comb begin
    state_d       = state_q;
    address_d     = address_q;
    read_d        = read_q;
    write_d       = write_q;
    writedata_d   = writedata_q;
    byteenable_d  = byteenable_q;
    we_d          = we_q;
    instr_valid_d = 1'b0;
    instr_rdata_d = instr_rdata_q;
    data_valid_d  = 1'b0;
    data_rdata_d  = data_rdata_q;
    bus_error_d   = bus_error_q;
    wd_cnt_d      = wd_cnt_q;

    case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        if (data_req) begin
          state_d      = DATA;
          address_d    = {data_addr[31:2], 2'b00};
          byteenable_d = data_be;
          writedata_d  = data_wdata;
          we_d         = data_we;
          read_d       = ~data_we;
          write_d      = data_we;
        end else if (instr_req) begin
          state_d      = FETCH;
          address_d    = {instr_addr[31:2], 2'b00};
          byteenable_d = '1;
          writedata_d  = '0;
          we_d         = 1'b0;
          read_d       = 1'b1;
          write_d      = 1'b0;
        end
      end

      FETCH, DATA: begin
        if (!waitrequest) begin
          state_d  = IDLE;
          read_d   = 1'b0;
          write_d  = 1'b0;
          wd_cnt_d = '0;
          if (state_q == FETCH) begin
            instr_valid_d = 1'b1;
            instr_rdata_d = readdata;
          end else begin
            data_valid_d = 1'b1;
            if (!we_q) data_rdata_d = readdata;
          end
        end else if (timeout_hit) begin
          state_d     = IDLE;
          read_d      = 1'b0;
          write_d     = 1'b0;
          wd_cnt_d    = '0;
          bus_error_d = 1'b1;
          if (state_q == FETCH) begin
            instr_valid_d = 1'b1;
            instr_rdata_d = '0;
          end else begin
            data_valid_d = 1'b1;
            if (!we_q) data_rdata_d = '0;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset drops any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      address_q     <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      writedata_q   <= '0;
      byteenable_q  <= '0;
      we_q          <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_rdata_q <= '0;
      data_valid_q  <= 1'b0;
      data_rdata_q  <= '0;
      bus_error_q   <= 1'b0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      read_q        <= read_d;
      write_q       <= write_d;
      writedata_q   <= writedata_d;
      byteenable_q  <= byteenable_d;
      we_q          <= we_d;
      instr_valid_q <= instr_valid_d;
      instr_rdata_q <= instr_rdata_d;
      data_valid_q  <= data_valid_d;
      data_rdata_q  <= data_rdata_d;
      bus_error_q   <= bus_error_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign instr_ready = (state_q == IDLE) && !data_req;
  assign data_ready  = (state_q == IDLE);
  assign instr_valid = instr_valid_q;
  assign instr_rdata = instr_rdata_q;
  assign data_valid  = data_valid_q;
  assign data_rdata  = data_rdata_q;
  assign address     = address_q;
  assign read        = read_q;
  assign write       = write_q;
  assign writedata   = writedata_q;
  assign byteenable  = byteenable_q;
  assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Directed bench for mips_cpu_bus_master with a 4-cycle watchdog.
module tb_mips_cpu_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_ready;
  logic        data_valid;
  logic [31:0] data_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        bus_error;

  int compared   = 0;
  int mismatched = 0;

  mips_cpu_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_ready(instr_ready),
    .instr_valid(instr_valid),
    .instr_rdata(instr_rdata),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_be    (data_be),
    .data_wdata (data_wdata),
    .data_ready (data_ready),
    .data_valid (data_valid),
    .data_rdata (data_rdata),
    .address    (address),
    .read       (read),
    .write      (write),
    .waitrequest(waitrequest),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (readdata),
    .bus_error  (bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_be = '0; data_wdata = '0;
    waitrequest = 1'b0; readdata = '0;
    tick; tick;
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_addr", address, 32'd0);
    chk("rst_berr", {31'd0, bus_error}, 32'd0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b0;
    tick;

    // Zero-wait fetch
    instr_req = 1'b1; instr_addr = 32'hBFC0_0000; readdata = 32'h2402_0005;
    #1 chk("f_iready", {31'd0, instr_ready}, 32'd1);
    tick;                                   // accept edge N
    instr_req = 1'b0;
    chk("f_read_n1", {31'd0, read}, 32'd1);
    chk("f_addr", address, 32'hBFC0_0000);
    chk("f_be", {28'd0, byteenable}, 32'hF);
    chk("f_ivalid_n1", {31'd0, instr_valid}, 32'd0);
    chk("f_iready_busy", {31'd0, instr_ready}, 32'd0);
    tick;                                   // completion edge
    chk("f_read_n2", {31'd0, read}, 32'd0);
    chk("f_ivalid_n2", {31'd0, instr_valid}, 32'd1);
    chk("f_rdata", instr_rdata, 32'h2402_0005);
    tick;
    chk("f_ivalid_n3", {31'd0, instr_valid}, 32'd0);

    // Load to seed data_rdata
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0100; data_be = 4'hF;
    readdata = 32'h1122_3344;
    tick;
    data_req = 1'b0;
    chk("l_read", {31'd0, read}, 32'd1);
    tick;
    chk("l_dvalid", {31'd0, data_valid}, 32'd1);
    chk("l_rdata", data_rdata, 32'h1122_3344);
    tick;

    // Store with 3 wait states
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_1006; data_be = 4'b1100;
    data_wdata = 32'hABCD_0000; waitrequest = 1'b1; readdata = 32'hDEAD_BEEF;
    tick;                                   // accept
    data_req = 1'b0;
    chk("s_write_c1", {31'd0, write}, 32'd1);
    chk("s_read_c1", {31'd0, read}, 32'd0);
    chk("s_addr", address, 32'h0000_1004);
    chk("s_be", {28'd0, byteenable}, 32'hC);
    chk("s_wdata", writedata, 32'hABCD_0000);
    tick;
    chk("s_write_c2", {31'd0, write}, 32'd1);
    tick;
    chk("s_write_c3", {31'd0, write}, 32'd1);
    chk("s_dready_busy", {31'd0, data_ready}, 32'd0);
    tick;
    chk("s_write_c4", {31'd0, write}, 32'd1);
    chk("s_addr_c4", address, 32'h0000_1004);
    chk("s_dvalid_c4", {31'd0, data_valid}, 32'd0);
    waitrequest = 1'b0;
    tick;
    chk("s_write_c5", {31'd0, write}, 32'd0);
    chk("s_dvalid_c5", {31'd0, data_valid}, 32'd1);
    chk("s_rdata_hold", data_rdata, 32'h1122_3344);
    chk("s_berr", {31'd0, bus_error}, 32'd0);
    tick;
    chk("s_dvalid_c6", {31'd0, data_valid}, 32'd0);

    // Simultaneous requests: data first
    instr_req = 1'b1; instr_addr = 32'h0000_0400;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_2000; data_be = 4'h3;
    readdata = 32'h0000_0055;
    #1 chk("a_iready", {31'd0, instr_ready}, 32'd0);
    chk("a_dready", {31'd0, data_ready}, 32'd1);
    tick;
    data_req = 1'b0;
    chk("a_addr_data", address, 32'h0000_2000);
    chk("a_be_data", {28'd0, byteenable}, 32'h3);
    chk("a_iready_busy", {31'd0, instr_ready}, 32'd0);
    tick;
    chk("a_dvalid", {31'd0, data_valid}, 32'd1);
    chk("a_drdata", data_rdata, 32'h0000_0055);
    chk("a_iready_idle", {31'd0, instr_ready}, 32'd1);
    readdata = 32'h0000_0066;
    tick;                                   // fetch accepted while data_valid high
    instr_req = 1'b0;
    chk("a_fread", {31'd0, read}, 32'd1);
    chk("a_faddr", address, 32'h0000_0400);
    chk("a_fbe", {28'd0, byteenable}, 32'hF);
    chk("a_dvalid_off", {31'd0, data_valid}, 32'd0);
    tick;
    chk("a_ivalid", {31'd0, instr_valid}, 32'd1);
    chk("a_irdata", instr_rdata, 32'h0000_0066);
    tick;

    // Watchdog abort after 4 stalled edges
    instr_req = 1'b1; instr_addr = 32'h0000_0800; waitrequest = 1'b1; readdata = 32'hFFFF_FFFF;
    tick;
    instr_req = 1'b0;
    chk("w_read_c1", {31'd0, read}, 32'd1);
    tick;
    tick;
    tick;
    chk("w_read_c4", {31'd0, read}, 32'd1);
    chk("w_berr_c4", {31'd0, bus_error}, 32'd0);
    tick;
    chk("w_read_c5", {31'd0, read}, 32'd0);
    chk("w_berr_c5", {31'd0, bus_error}, 32'd1);
    chk("w_ivalid", {31'd0, instr_valid}, 32'd1);
    chk("w_irdata", instr_rdata, 32'd0);
    waitrequest = 1'b0;
    tick;
    chk("w_ivalid_off", {31'd0, instr_valid}, 32'd0);
    chk("w_berr_sticky", {31'd0, bus_error}, 32'd1);

    // Reset in the middle of a stalled load
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_3000; data_be = 4'hF;
    waitrequest = 1'b1; readdata = 32'h0000_0099;
    tick;
    data_req = 1'b0;
    chk("r_read_pre", {31'd0, read}, 32'd1);
    tick;
    reset = 1'b1;
    #1 chk("r_read_async", {31'd0, read}, 32'd0);
    chk("r_dready", {31'd0, data_ready}, 32'd1);
    chk("r_berr_clr", {31'd0, bus_error}, 32'd0);
    #2 reset = 1'b0;
    waitrequest = 1'b0;
    tick;
    chk("r_no_dvalid", {31'd0, data_valid}, 32'd0);
    data_req = 1'b1; data_addr = 32'h0000_3008; readdata = 32'h0000_0077;
    tick;
    data_req = 1'b0;
    chk("r2_read", {31'd0, read}, 32'd1);
    chk("r2_addr", address, 32'h0000_3008);
    tick;
    chk("r2_dvalid", {31'd0, data_valid}, 32'd1);
    chk("r2_rdata", data_rdata, 32'h0000_0077);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
